mdma_80bx256_ram_arb: RTL and testbench
=======================================

Name: mdma_80bx256_ram_arb

Overview:
Two-client arbiter and sequencer for one 80-bit x 256-entry RAM with single/double-bit error reporting. After reset it zero-fills all 256 entries. It then grants one read or write per cycle to client A or B, round-robin on contention. It returns read data to the issuing client with a fixed latency and keeps error counters and a sticky double-bit-error capture. It sits between the queue-context logic (two requesters) and the RAM master port.

Parameters:
RD_LAT, 2, RAM read latency in clk cycles from ren to rdat/rsbe/rdbe valid (1..4)
CNT_W, 16, width of saturating error counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ca_req  in  1  client A request valid
ca_we  in  1  client A 1=write, 0=read
ca_adr  in  8  client A address
ca_wdat  in  80  client A write data
ca_gnt  out  1  client A request accepted this cycle
ca_rvld  out  1  client A read data valid
cb_req, cb_we, cb_adr, cb_wdat, cb_gnt, cb_rvld  (same as client A, for client B)
rdat_o  out  80  read data, shared by both clients, qualified by ca_rvld/cb_rvld
rsbe_o  out  1  single-bit error flag with rdat_o
rdbe_o  out  1  double-bit error flag with rdat_o
ram_wadr  out  8  RAM write address
ram_wen  out  1  RAM write enable
ram_wdat  out  80  RAM write data
ram_ren  out  1  RAM read enable
ram_radr  out  8  RAM read address
ram_rdat  in  80  RAM read data
ram_rsbe  in  1  RAM single-bit error
ram_rdbe  in  1  RAM double-bit error
init_done  out  1  zero-fill complete, clients may be granted
sbe_cnt  out  CNT_W  saturating count of single-bit errors
dbe_cnt  out  CNT_W  saturating count of double-bit errors
dbe_err  out  1  sticky double-bit error seen
dbe_adr  out  8  address of first double-bit error
err_clr  in  1  clears sbe_cnt, dbe_cnt, dbe_err, dbe_adr

Behaviour:
- Reset (rst=1 at a clk edge) drives all outputs to 0, state to INIT, init address to 0, round-robin pointer to A, and empties the read pipeline. Reset mid-operation discards in-flight reads: no rvld afterwards, and the zero-fill restarts.
- States: INIT and RUN.
- INIT: each cycle drives ram_wen=1, ram_wadr=init_adr, ram_wdat=0, then init_adr increments. After address 255 is written, the next state is RUN and init_done=1 from that cycle. INIT lasts exactly 256 cycles after reset deassertion. ca_gnt and cb_gnt are 0 and ram_ren is 0 throughout INIT.
- RUN arbitration is combinational within the cycle:
  - Only one request: that client is granted.
  - Both requesting: the client pointed to by rr_ptr is granted, and rr_ptr toggles to the other client.
  - Single request: rr_ptr is set to the other client.
  - No request: rr_ptr holds.
- A grant has the same cycle as req. A client holds req/adr/we/wdat until it sees gnt.
- Granted write: ram_wen=1, ram_wadr=adr, ram_wdat=wdat in the same cycle. Write drives are registered-free, i.e. combinational from the grant mux.
- Granted read: ram_ren=1, ram_radr=adr in the same cycle.
- ram_wen and ram_ren are never both 1 in a cycle. The RAM interface carries at most one operation per cycle.
- Read return: a tag pipeline of depth RD_LAT carries {valid, client, adr}. Exactly RD_LAT cycles after ram_ren:
  - ca_rvld or cb_rvld (per tag) is 1;
  - rdat_o, rsbe_o and rdbe_o equal ram_rdat, ram_rsbe and ram_rdbe, passed combinationally.
  - Back-to-back reads return back-to-back in issue order.
- Read-after-write to the same address on consecutive cycles returns the new data. The RAM guarantees this; the block adds no bypass.
- Error logic (RUN, on a returning read):
  - rsbe increments sbe_cnt, saturating at all-ones.
  - rdbe increments dbe_cnt, saturating at all-ones.
  - On the first rdbe while dbe_err=0: set dbe_err=1 and capture dbe_adr from the tag. Later rdbe events do not overwrite dbe_adr.
  - rsbe and rdbe together count both.
  - err_clr in the same cycle as an error event: clear wins, and the event is not counted.
- rsbe/rdbe are ignored when no tag is valid.

Test Plan:
- Reset release, no requests -> ram_wen=1 with ram_wdat=0 for 256 consecutive cycles at addresses 0..255; init_done rises on cycle 256; no gnt during INIT.
- After init, A writes 80'h1234 at 0x10, then B reads 0x10 -> cb_gnt next cycle; cb_rvld exactly RD_LAT=2 cycles after grant with rdat_o=80'h1234; ca_rvld stays 0.
- A and B hold continuous read requests for 6 cycles -> grants alternate A,B,A,B,A,B; ram_ren=1 every cycle; rvld pattern is the same sequence delayed by 2.
- ram_rdbe forced on reads to 0x22 and then 0x30 -> dbe_cnt=2, dbe_err=1, dbe_adr=0x22; err_clr pulse -> all cleared.
- sbe_cnt preset to 0xFFFE by injecting errors, then 3 more sbe events -> sbe_cnt saturates at 0xFFFF.
- rst asserted one cycle after a read grant -> no rvld ever appears for that read; INIT restarts at address 0.

Source files
------------

// File: rtl/mdma_80bx256_ram_arb.sv
// -----------------------------------------------------------------------------
// mdma_80bx256_ram_arb
//
// Arbiter and sequencer for one 80-bit x 256-entry RAM that is shared by two
// queue-context clients (A and B).
//
// After reset the block zero-fills every RAM entry, one write per cycle, and
// then raises init_done. From then on it grants at most one client operation
// per cycle. Grants are round-robin when both clients request. Grants,
// RAM write drives and RAM read drives are all combinational in the request
// cycle.
//
// Read data comes back RD_LAT cycles after ram_ren. A tag pipeline remembers
// which client issued the read and which address it used. The tag steers
// ca_rvld/cb_rvld and supplies the address that is captured on the first
// double-bit error.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ca_* / cb_*                   client request (req, we, adr, wdat),
//                                 grant (gnt) and read-valid (rvld)
//   rdat_o, rsbe_o, rdbe_o        returned read data and error flags
//   ram_wen/wadr/wdat             RAM write port
//   ram_ren/radr                  RAM read port
//   ram_rdat/rsbe/rdbe            RAM read data and error flags
//   init_done                     zero-fill complete
//   sbe_cnt, dbe_cnt              saturating error counters
//   dbe_err, dbe_adr              sticky first double-bit-error capture
//   err_clr                       clears the counters and the capture
// -----------------------------------------------------------------------------
module mdma_80bx256_ram_arb #(
    parameter int RD_LAT = 2,   // RAM read latency, 1..4
    parameter int CNT_W  = 16   // error counter width
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             ca_req,
    input  logic             ca_we,
    input  logic [7:0]       ca_adr,
    input  logic [79:0]      ca_wdat,
    output logic             ca_gnt,
    output logic             ca_rvld,

    input  logic             cb_req,
    input  logic             cb_we,
    input  logic [7:0]       cb_adr,
    input  logic [79:0]      cb_wdat,
    output logic             cb_gnt,
    output logic             cb_rvld,

    output logic [79:0]      rdat_o,
    output logic             rsbe_o,
    output logic             rdbe_o,

    output logic [7:0]       ram_wadr,
    output logic             ram_wen,
    output logic [79:0]      ram_wdat,
    output logic             ram_ren,
    output logic [7:0]       ram_radr,
    input  logic [79:0]      ram_rdat,
    input  logic             ram_rsbe,
    input  logic             ram_rdbe,

    output logic             init_done,
    output logic [CNT_W-1:0] sbe_cnt,
    output logic [CNT_W-1:0] dbe_cnt,
    output logic             dbe_err,
    output logic [7:0]       dbe_adr,
    input  logic             err_clr
);

    localparam int LAST = RD_LAT - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // --------------------------------------------------------------------
    // State
    // --------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [7:0]        init_adr_q, init_adr_d;
    logic              rr_ptr_q,   rr_ptr_d;      // 0 = A next, 1 = B next

    logic [RD_LAT-1:0] tag_vld_q,  tag_vld_d;
    logic [RD_LAT-1:0] tag_cli_q,  tag_cli_d;     // 0 = A, 1 = B
    logic [7:0]        tag_adr_q [RD_LAT];
    logic [7:0]        tag_adr_d [RD_LAT];

    logic [CNT_W-1:0]  sbe_cnt_q,  sbe_cnt_d;
    logic [CNT_W-1:0]  dbe_cnt_q,  dbe_cnt_d;
    logic              dbe_err_q,  dbe_err_d;
    logic [7:0]        dbe_adr_q,  dbe_adr_d;

    // --------------------------------------------------------------------
    // Combinational datapath
    // --------------------------------------------------------------------
    logic        init_wr;
    logic        run;
    logic        gnt_a, gnt_b, any_gnt;
    logic        sel_we;
    logic [7:0]  sel_adr;
    logic [79:0] sel_wdat;
    logic        wr_gnt, rd_gnt;
    logic        out_vld, out_cli;
    logic [7:0]  out_adr;
    logic        ev_sbe, ev_dbe;

    // The oldest tag stage lines up with the RAM output. The stage is gated
    // by rst, so nothing reaches the clients while reset is held. This also
    // covers RD_LAT = 1.
    assign out_vld = tag_vld_q[LAST] & ~rst;
    assign out_cli = tag_cli_q[LAST];
    assign out_adr = tag_adr_q[LAST];
    assign ev_sbe  = out_vld & ram_rsbe;
    assign ev_dbe  = out_vld & ram_rdbe;

    // NOTE: every always_comb output gets a default before any branch. A path
    // that leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        init_adr_d = init_adr_q;
        rr_ptr_d   = rr_ptr_q;

        init_wr = ~rst && (state_q == ST_INIT);
        run     = ~rst && (state_q == ST_RUN);

        // Round-robin grant. With a single requester, that client wins
        // outright. On contention, rr_ptr picks the winner.
        gnt_a   = run & ca_req & (~cb_req | ~rr_ptr_q);
        gnt_b   = run & cb_req & (~ca_req |  rr_ptr_q);
        any_gnt = gnt_a | gnt_b;

        if (run) begin
            if (ca_req && cb_req) begin
                rr_ptr_d = ~rr_ptr_q;
            end else if (ca_req) begin
                rr_ptr_d = 1'b1;
            end else if (cb_req) begin
                rr_ptr_d = 1'b0;
            end
        end

        sel_we   = gnt_b ? cb_we   : ca_we;
        sel_adr  = gnt_b ? cb_adr  : ca_adr;
        sel_wdat = gnt_b ? cb_wdat : ca_wdat;
        wr_gnt   = any_gnt &  sel_we;
        rd_gnt   = any_gnt & ~sel_we;

        // The zero-fill owns the write port during INIT. No grants are
        // issued then, so it never collides with a client operation.
        ram_wen  = init_wr | wr_gnt;
        ram_wadr = init_wr ? init_adr_q : (wr_gnt ? sel_adr : 8'h00);
        ram_wdat = wr_gnt ? sel_wdat : '0;
        ram_ren  = rd_gnt;
        ram_radr = rd_gnt ? sel_adr : 8'h00;

        if (init_wr) begin
            init_adr_d = init_adr_q + 8'd1;
            if (init_adr_q == 8'hFF) begin
                state_d = ST_RUN;
            end
        end

        // Tag pipeline: stage 0 loads on a read grant, the others shift.
        tag_vld_d    = tag_vld_q;
        tag_cli_d    = tag_cli_q;
        tag_adr_d    = tag_adr_q;
        tag_vld_d[0] = rd_gnt;
        tag_cli_d[0] = gnt_b;
        tag_adr_d[0] = sel_adr;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_cli_d[i] = tag_cli_q[i-1];
            tag_adr_d[i] = tag_adr_q[i-1];
        end

        // Error bookkeeping. When err_clr coincides with an error event,
        // the clear wins and the event is dropped.
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        dbe_err_d = dbe_err_q;
        dbe_adr_d = dbe_adr_q;
        if (err_clr) begin
            sbe_cnt_d = '0;
            dbe_cnt_d = '0;
            dbe_err_d = 1'b0;
            dbe_adr_d = 8'h00;
        end else begin
            if (ev_sbe && (sbe_cnt_q != {CNT_W{1'b1}})) begin
                sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
            end
            if (ev_dbe && (dbe_cnt_q != {CNT_W{1'b1}})) begin
                dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
            end
            if (ev_dbe && !dbe_err_q) begin
                dbe_err_d = 1'b1;
                dbe_adr_d = out_adr;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together, and reading order inside the block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_adr_q <= 8'h00;
            rr_ptr_q   <= 1'b0;
            tag_vld_q  <= '0;
            sbe_cnt_q  <= '0;
            dbe_cnt_q  <= '0;
            dbe_err_q  <= 1'b0;
            dbe_adr_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            init_adr_q <= init_adr_d;
            rr_ptr_q   <= rr_ptr_d;
            tag_vld_q  <= tag_vld_d;
            sbe_cnt_q  <= sbe_cnt_d;
            dbe_cnt_q  <= dbe_cnt_d;
            dbe_err_q  <= dbe_err_d;
            dbe_adr_q  <= dbe_adr_d;
        end
    end

    // NOTE: tag payload (client, address) is not reset. It is only looked at
    // when the matching valid bit is set, and clearing the valid bits is
    // enough to empty the pipeline.
    always_ff @(posedge clk) begin
        tag_cli_q <= tag_cli_d;
        tag_adr_q <= tag_adr_d;
    end

    // --------------------------------------------------------------------
    // Outputs
    // --------------------------------------------------------------------
    assign ca_gnt    = gnt_a;
    assign cb_gnt    = gnt_b;
    assign ca_rvld   = out_vld & ~out_cli;
    assign cb_rvld   = out_vld &  out_cli;
    assign rdat_o    = out_vld ? ram_rdat : '0;
    assign rsbe_o    = out_vld & ram_rsbe;
    assign rdbe_o    = out_vld & ram_rdbe;
    assign init_done = ~rst && (state_q == ST_RUN);
    assign sbe_cnt   = sbe_cnt_q;
    assign dbe_cnt   = dbe_cnt_q;
    assign dbe_err   = dbe_err_q;
    assign dbe_adr   = dbe_adr_q;

endmodule

// File: tb/tb_mdma_80bx256_ram_arb.sv
// -----------------------------------------------------------------------------
// tb_mdma_80bx256_ram_arb
//
// Self-checking bench for mdma_80bx256_ram_arb (RD_LAT = 2, CNT_W = 16).
//
// A behavioural RAM model answers reads after two cycles. Per read, the model
// can inject single- or double-bit error flags.
//
// The per-cycle monitor (tick) checks the following:
//   - the zero-fill sequence;
//   - the arbitration, against an independent round-robin model;
//   - the RAM drives.
// It also pushes expected read returns to a queue and pops them when rvld
// appears.
// -----------------------------------------------------------------------------
module tb_mdma_80bx256_ram_arb;

    localparam int RD_LAT = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             ca_req, ca_we, cb_req, cb_we;
    logic [7:0]       ca_adr, cb_adr;
    logic [79:0]      ca_wdat, cb_wdat;
    logic             ca_gnt, ca_rvld, cb_gnt, cb_rvld;
    logic [79:0]      rdat_o;
    logic             rsbe_o, rdbe_o;
    logic [7:0]       ram_wadr, ram_radr;
    logic             ram_wen, ram_ren;
    logic [79:0]      ram_wdat, ram_rdat;
    logic             ram_rsbe, ram_rdbe;
    logic             init_done;
    logic [CNT_W-1:0] sbe_cnt, dbe_cnt;
    logic             dbe_err;
    logic [7:0]       dbe_adr;
    logic             err_clr;

    logic             inj_sbe, inj_dbe;

    always #5 clk = ~clk;

    mdma_80bx256_ram_arb #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ca_req(ca_req), .ca_we(ca_we), .ca_adr(ca_adr), .ca_wdat(ca_wdat),
        .ca_gnt(ca_gnt), .ca_rvld(ca_rvld),
        .cb_req(cb_req), .cb_we(cb_we), .cb_adr(cb_adr), .cb_wdat(cb_wdat),
        .cb_gnt(cb_gnt), .cb_rvld(cb_rvld),
        .rdat_o(rdat_o), .rsbe_o(rsbe_o), .rdbe_o(rdbe_o),
        .ram_wadr(ram_wadr), .ram_wen(ram_wen), .ram_wdat(ram_wdat),
        .ram_ren(ram_ren), .ram_radr(ram_radr),
        .ram_rdat(ram_rdat), .ram_rsbe(ram_rsbe), .ram_rdbe(ram_rdbe),
        .init_done(init_done), .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
        .dbe_err(dbe_err), .dbe_adr(dbe_adr), .err_clr(err_clr)
    );

    // ------------------------------------------------------------------
    // RAM model: two-stage read pipeline, write on the clock edge
    // ------------------------------------------------------------------
    logic [79:0] mem [256];
    logic [79:0] p0_dat, p1_dat;
    logic        p0_sbe, p0_dbe, p1_sbe, p1_dbe;

    always @(posedge clk) begin
        if (ram_wen) mem[ram_wadr] <= ram_wdat;
        p0_dat <= ram_ren ? mem[ram_radr] : 80'h0;
        p0_sbe <= ram_ren & inj_sbe;
        p0_dbe <= ram_ren & inj_dbe;
        p1_dat <= p0_dat;
        p1_sbe <= p0_sbe;
        p1_dbe <= p0_dbe;
    end
    assign ram_rdat = p1_dat;
    assign ram_rsbe = p1_sbe;
    assign ram_rdbe = p1_dbe;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        cli;
        logic [79:0] dat;
        logic        sbe;
        logic        dbe;
    } exp_t;

    exp_t        rq[$];
    logic [79:0] exp_mem [256];
    int          cyc      = 0;
    bit          run_m    = 1'b0;
    int          init_cnt = 0;
    logic        rr_m     = 1'b0;
    logic        last_ga, last_gb;

    // One clock cycle: sample at the falling edge, then advance to just
    // after the next rising edge, where the stimulus may change.
    task automatic tick();
        logic ega, egb, ewe;
        logic [7:0]  eadr;
        logic [79:0] ewd;
        exp_t e;
        @(negedge clk);
        cyc++;
        last_ga = ca_gnt;
        last_gb = cb_gnt;
        if (rst) begin
            check("rst_outs", {ca_gnt, cb_gnt, ca_rvld, cb_rvld, ram_wen,
                               ram_ren, init_done}, 80'h0);
        end else if (!run_m) begin
            check("init_wen",  ram_wen, 1'b1);
            check("init_wadr", ram_wadr, init_cnt[7:0]);
            check("init_wdat", ram_wdat, 80'h0);
            check("init_quiet", {ca_gnt, cb_gnt, ram_ren, init_done}, 80'h0);
        end else begin
            ega = ca_req & (~cb_req | ~rr_m);
            egb = cb_req & (~ca_req |  rr_m);
            check("init_done", init_done, 1'b1);
            check("gnt", {ca_gnt, cb_gnt}, {ega, egb});
            ewe  = egb ? cb_we   : ca_we;
            eadr = egb ? cb_adr  : ca_adr;
            ewd  = egb ? cb_wdat : ca_wdat;
            if ((ega | egb) && ewe) begin
                check("wr_en",   {ram_wen, ram_ren}, 2'b10);
                check("wr_adr",  ram_wadr, eadr);
                check("wr_dat",  ram_wdat, ewd);
                exp_mem[eadr] = ewd;
            end else if (ega | egb) begin
                check("rd_en",  {ram_wen, ram_ren}, 2'b01);
                check("rd_adr", ram_radr, eadr);
                e.due = cyc + RD_LAT;
                e.cli = egb;
                e.dat = exp_mem[eadr];
                e.sbe = inj_sbe;
                e.dbe = inj_dbe;
                rq.push_back(e);
            end else begin
                check("idle_en", {ram_wen, ram_ren}, 2'b00);
            end
            if (ca_req && cb_req)  rr_m = ~rr_m;
            else if (ca_req)       rr_m = 1'b1;
            else if (cb_req)       rr_m = 1'b0;
        end

        // Read-return scoreboard
        if (!rst) begin
            if (ca_rvld || cb_rvld) begin
                if (rq.size() == 0) begin
                    check("rvld_unexpected", {ca_rvld, cb_rvld}, 2'b00);
                end else begin
                    e = rq.pop_front();
                    check("rd_time",   cyc, e.due);
                    check("rd_client", {ca_rvld, cb_rvld}, {~e.cli, e.cli});
                    check("rd_data",   rdat_o, e.dat);
                    check("rd_err",    {rsbe_o, rdbe_o}, {e.sbe, e.dbe});
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                check("rvld_missing", 1'b0, 1'b1);
                void'(rq.pop_front());
            end
        end

        // Reference state update
        if (rst) begin
            run_m    = 1'b0;
            init_cnt = 0;
            rr_m     = 1'b0;
            rq.delete();
            for (int i = 0; i < 256; i++) exp_mem[i] = 80'h0;
        end else if (!run_m) begin
            init_cnt++;
            if (init_cnt == 256) run_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ca_req = 0; ca_we = 0; ca_adr = 0; ca_wdat = 0;
        cb_req = 0; cb_we = 0; cb_adr = 0; cb_wdat = 0;
    endtask

    // Single operation from one client, held until granted.
    task automatic do_op(input logic cli, input logic we, input logic [7:0] adr,
                         input logic [79:0] wd);
        bit got = 0;
        idle_inputs();
        if (cli) begin cb_req = 1; cb_we = we; cb_adr = adr; cb_wdat = wd; end
        else     begin ca_req = 1; ca_we = we; ca_adr = adr; ca_wdat = wd; end
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            got = cli ? last_gb : last_ga;
        end
        if (!got) check("op_timeout", 1'b0, 1'b1);
        idle_inputs();
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && rq.size() != 0; i++) tick();
        check("drain_empty", rq.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Arbitration vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        a_req, a_we;
        logic [7:0]  a_adr;
        logic [79:0] a_wd;
        logic        b_req, b_we;
        logic [7:0]  b_adr;
        logic [79:0] b_wd;
        logic        exp_ga, exp_gb;
    } vec_t;

    vec_t tbl [9];
    logic gseq [6];

    initial begin
        tbl[0] = '{1, 0, 8'h01, 80'h0, 1, 0, 8'h41, 80'h0,    1, 0};
        tbl[1] = '{1, 0, 8'h02, 80'h0, 1, 0, 8'h42, 80'h0,    0, 1};
        tbl[2] = '{1, 0, 8'h03, 80'h0, 0, 0, 8'h00, 80'h0,    1, 0};
        tbl[3] = '{1, 0, 8'h04, 80'h0, 1, 0, 8'h44, 80'h0,    0, 1};
        tbl[4] = '{0, 0, 8'h00, 80'h0, 1, 0, 8'h45, 80'h0,    0, 1};
        tbl[5] = '{0, 0, 8'h00, 80'h0, 0, 0, 8'h00, 80'h0,    0, 0};
        tbl[6] = '{1, 0, 8'h07, 80'h0, 1, 0, 8'h47, 80'h0,    1, 0};
        tbl[7] = '{0, 0, 8'h00, 80'h0, 1, 1, 8'h48, 80'hBEEF, 0, 1};
        tbl[8] = '{1, 0, 8'h48, 80'h0, 1, 0, 8'h49, 80'h0,    1, 0};

        idle_inputs();
        rst = 1; err_clr = 0; inj_sbe = 0; inj_dbe = 0;
        repeat (3) tick();
        rst = 0;

        // Zero-fill: the monitor checks every address 0..255 in order.
        repeat (256) tick();
        check("init_done_rise", init_done, 1'b1);
        check("cnt_reset", {sbe_cnt, dbe_cnt, dbe_err, dbe_adr}, 80'h0);

        // Table-driven arbitration; the pointer starts at A after reset.
        foreach (tbl[i]) begin
            ca_req = tbl[i].a_req; ca_we = tbl[i].a_we;
            ca_adr = tbl[i].a_adr; ca_wdat = tbl[i].a_wd;
            cb_req = tbl[i].b_req; cb_we = tbl[i].b_we;
            cb_adr = tbl[i].b_adr; cb_wdat = tbl[i].b_wd;
            tick();
            check($sformatf("tbl%0d_gnt", i), {last_ga, last_gb},
                  {tbl[i].exp_ga, tbl[i].exp_gb});
        end
        idle_inputs();
        drain();

        // A writes, B reads the same address back.
        do_op(1'b0, 1'b1, 8'h10, 80'h1234);
        do_op(1'b1, 1'b0, 8'h10, 80'h0);
        drain();

        // Both clients stream reads for 6 cycles; a B-only read first
        // leaves the pointer at A.
        do_op(1'b1, 1'b0, 8'h11, 80'h0);
        ca_req = 1; ca_adr = 8'h50; cb_req = 1; cb_adr = 8'h10;
        for (int i = 0; i < 6; i++) begin
            tick();
            gseq[i] = last_gb;
            check("alt_one_gnt", last_ga ^ last_gb, 1'b1);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) check("alt_order", gseq[i], i % 2);
        drain();

        // Double-bit errors on 0x22 then 0x30.
        inj_dbe = 1;
        do_op(1'b0, 1'b0, 8'h22, 80'h0);
        do_op(1'b1, 1'b0, 8'h30, 80'h0);
        inj_dbe = 0;
        drain();
        check("dbe_cnt", dbe_cnt, 16'd2);
        check("dbe_err", dbe_err, 1'b1);
        check("dbe_adr", dbe_adr, 8'h22);
        check("sbe_cnt_0", sbe_cnt, 16'd0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("err_clr", {sbe_cnt, dbe_cnt, dbe_err, dbe_adr}, 80'h0);

        // Single-bit error saturation: 0xFFFE events, then 3 more.
        inj_sbe = 1;
        ca_req = 1; ca_adr = 8'h05;
        repeat (16'hFFFE) tick();
        idle_inputs();
        drain();
        check("sbe_fffe", sbe_cnt, 16'hFFFE);
        repeat (3) do_op(1'b0, 1'b0, 8'h06, 80'h0);
        drain();
        check("sbe_sat", sbe_cnt, 16'hFFFF);
        check("dbe_cnt_0", dbe_cnt, 16'd0);

        // err_clr in the return cycle beats the sbe event.
        do_op(1'b0, 1'b0, 8'h07, 80'h0);
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        inj_sbe = 0;
        check("clr_wins", sbe_cnt, 16'd0);
        check("clr_wins_q", rq.size(), 0);

        // Reset one cycle after a read grant; the read must never return.
        do_op(1'b0, 1'b0, 8'h40, 80'h0);
        rst = 1;
        repeat (2) tick();
        rst = 0;
        ca_req = 1; ca_adr = 8'h10;      // held through INIT: no grant allowed
        repeat (256) tick();
        check("reinit_done", init_done, 1'b1);
        tick();                           // first RUN cycle grants A
        check("post_init_gnt", last_ga, 1'b1);
        idle_inputs();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
